// File: rtl/acpram_axi_arbiter.sv
// acpram_axi_arbiter: round-robin arbiter sharing one ACPRAM<->AXI burst engine
// between NREQ requesters. One transaction outstanding at a time; the command
// is latched at the handshake and held until the engine reports done.
// Optional build macro ACPRAM_AXI_ARB_TIMEOUT_EN adds a WAIT-state watchdog
// that completes the transaction with an error after TIMEOUT_CYCLES.
module acpram_axi_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned ACPRAM_AW      = 10,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_write,
    input  logic [NREQ-1:0]           req_len,
    input  logic [NREQ*ACPRAM_AW-1:0] req_acpram_addr,
    input  logic [NREQ*40-1:0]        req_axi_addr,
    output logic [NREQ-1:0]           resp_done,
    output logic [NREQ-1:0]           resp_error,
    output logic                      eng_write,
    output logic                      eng_read,
    output logic                      eng_len,
    output logic [ACPRAM_AW-1:0]      eng_acpram_addr,
    output logic [39:0]               eng_axi_addr,
    input  logic                      eng_busy,
    input  logic                      eng_done,
    input  logic                      eng_error,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      active
);

    localparam int unsigned IW = $clog2(NREQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Elaboration-time parameter sanity.
    if (NREQ < 2 || NREQ > 8) begin : g_nreq_range
        $error("NREQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_tmo_range
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [IW-1:0]        r_rr;
    logic [IW-1:0]        r_owner;
    logic                 r_active;
    logic                 r_eng_write;
    logic                 r_eng_read;
    logic                 r_eng_len;
    logic [ACPRAM_AW-1:0] r_eng_acpram_addr;
    logic [39:0]          r_eng_axi_addr;
    logic [NREQ-1:0]      r_resp_done;
    logic [NREQ-1:0]      r_resp_error;

    logic                 w_grant_found;
    logic [IW-1:0]        w_grant_idx;
    logic [IW-1:0]        w_scan_idx;
    logic [IW-1:0]        w_rr_nxt;
    logic                 w_can_grant;
    logic                 w_timeout;
    logic [NREQ-1:0]      w_owner_oh;
    logic [ACPRAM_AW-1:0] w_acp_arr [NREQ];
    logic [39:0]          w_axi_arr [NREQ];

    // Unpack the per-requester address buses.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_acp_arr[gi] = req_acpram_addr[gi*ACPRAM_AW +: ACPRAM_AW];
        assign w_axi_arr[gi] = req_axi_addr[gi*40 +: 40];
    end

    // Round-robin scan: first valid requester at or after rr, wrapping.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan_idx = IW'((32'(r_rr) + 32'(k)) % NREQ);
            if (!w_grant_found && req_valid[w_scan_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan_idx;
            end
        end
    end

    assign w_can_grant = resetn && (r_state == ST_IDLE) && !eng_busy && w_grant_found;
    assign w_rr_nxt    = IW'((32'(w_grant_idx) + 32'd1) % NREQ);
    assign w_owner_oh  = NREQ'(1) << r_owner;
    assign req_ready   = w_can_grant ? (NREQ'(1) << w_grant_idx) : '0;

`ifdef ACPRAM_AXI_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_tmo_cnt;

    // Watchdog: cleared while issuing, counts every cycle spent waiting.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_can_grant) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (eng_done || w_timeout) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, engine pulses, grant bookkeeping and response pulses.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_rr              <= '0;
            r_owner           <= '0;
            r_active          <= 1'b0;
            r_eng_write       <= 1'b0;
            r_eng_read        <= 1'b0;
            r_eng_len         <= 1'b0;
            r_eng_acpram_addr <= '0;
            r_eng_axi_addr    <= '0;
            r_resp_done       <= '0;
            r_resp_error      <= '0;
        end else begin
            r_eng_write  <= 1'b0;
            r_eng_read   <= 1'b0;
            r_resp_done  <= '0;
            r_resp_error <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_can_grant) begin
                        r_eng_len         <= req_len[w_grant_idx];
                        r_eng_acpram_addr <= w_acp_arr[w_grant_idx];
                        r_eng_axi_addr    <= w_axi_arr[w_grant_idx];
                        r_eng_write       <= req_write[w_grant_idx];
                        r_eng_read        <= ~req_write[w_grant_idx];
                        r_owner           <= w_grant_idx;
                        r_rr              <= w_rr_nxt;
                        r_active          <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        r_resp_done  <= w_owner_oh;
                        r_resp_error <= eng_error ? w_owner_oh : '0;
                        r_active     <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_done  <= w_owner_oh;
                        r_resp_error <= w_owner_oh;
                        r_active     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_write       = r_eng_write;
    assign eng_read        = r_eng_read;
    assign eng_len         = r_eng_len;
    assign eng_acpram_addr = r_eng_acpram_addr;
    assign eng_axi_addr    = r_eng_axi_addr;
    assign resp_done       = r_resp_done;
    assign resp_error      = r_resp_error;
    assign owner           = r_owner;
    assign active          = r_active;

endmodule

// File: doc/acpram_axi_arbiter.md
Name: acpram_axi_arbiter

Overview:
Shares one ACPRAM↔AXI burst engine between NREQ requesters, for example RX/TX descriptor and buffer movers. The block takes requests through per-requester valid/ready handshakes and grants them round-robin. It issues one command pulse to the engine, holds the command fields stable until the engine signals done, and routes the done/error pulse back to the owning requester. At most one transaction is outstanding at any time.

Parameters:
NREQ, 4, number of requesters (2..8)
ACPRAM_AW, 10, ACPRAM word-address width
TIMEOUT_CYCLES, 4096, watchdog limit in cycles (used only with the optional feature)

Ports:
clock  in  1  clock
resetn  in  1  synchronous active-low reset
req_valid  in  NREQ  request pending, one bit per requester
req_ready  out  NREQ  request accepted (one-hot when active)
req_write  in  NREQ  1=ACPRAM→AXI write, 0=AXI→ACPRAM read
req_len  in  NREQ  0=1 beat, 1=4 beats (16 B per beat)
req_acpram_addr  in  NREQ*ACPRAM_AW  packed, requester i at [i*ACPRAM_AW +: ACPRAM_AW]
req_axi_addr  in  NREQ*40  packed, 40-bit AXI address per requester
resp_done  out  NREQ  one-cycle completion pulse to the owner
resp_error  out  NREQ  error qualifier, valid only with resp_done
eng_write  out  1  engine write pulse
eng_read  out  1  engine read pulse
eng_len  out  1  length to engine
eng_acpram_addr  out  ACPRAM_AW  ACPRAM address to engine
eng_axi_addr  out  40  AXI address to engine
eng_busy  in  1  engine busy
eng_done  in  1  engine done pulse
eng_error  in  1  engine error, sampled with eng_done
owner  out  $clog2(NREQ)  index of the current or last grant
active  out  1  a transaction is outstanding

Behaviour:
- Reset (resetn=0 at posedge): all outputs go to 0; state=IDLE; round-robin pointer rr=0. Reset mid-transaction aborts tracking with no resp_done. The engine shares the same reset.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - req_ready is combinational: one-hot on the first i with req_valid[i]=1, scanning from rr upward modulo NREQ. The state must be IDLE and eng_busy=0; otherwise req_ready=0.
  - On handshake (valid&ready for index g):
    - latch eng_len, eng_acpram_addr, eng_axi_addr and direction from requester g;
    - set owner=g and rr=(g+1) mod NREQ;
    - go to ISSUE.
- ISSUE (exactly 1 cycle):
  - eng_write=dir, eng_read=~dir. Both are registered, one-cycle pulses and never asserted together.
  - active=1; go to WAIT.
- WAIT:
  - Command fields are held stable; active=1.
  - On eng_done: resp_done[owner]=1 and resp_error[owner]=eng_error for exactly the next cycle (registered); active=0; go to IDLE.
  - eng_done seen in IDLE or ISSUE is ignored.
- Latency: handshake in cycle N → engine pulse in cycle N+1 → resp_done in the cycle after eng_done. The earliest next grant is in the same cycle resp_done is asserted.
- A requester may drop req_valid before it is granted; no grant results.
- Requester inputs are sampled only at the handshake.
- Single requester, back-to-back: grants every transaction; rr wraps past NREQ-1 to 0.
- Lone requester g=NREQ-1: rr becomes 0, and g is still granted next because the scan wraps.

Optional Feature:
ACPRAM_AXI_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on ISSUE and increments in WAIT.
  - When it reaches TIMEOUT_CYCLES: pulse resp_done[owner] with resp_error[owner]=1 and go to IDLE.
  - Further requests stay blocked until eng_busy=0.
  - A late eng_done is then ignored.
- Undefined: no counter is built; WAIT exits only on eng_done.

Test Plan:
- Req0 write, len=0, acpram=0x010, axi=0x80001000; engine done 20 cycles later → eng_write pulse 1 cycle after handshake with fields matching; resp_done[0] pulse with resp_error=0.
- req_valid=4'b1111 held through 8 transactions → grant order 0,1,2,3,0,1,2,3; each req_ready one-hot for 1 cycle.
- Req2 read len=1 with eng_error=1 on done → eng_read pulse, eng_len=1; resp_error[2]=1 only in the resp_done cycle; other resp bits stay 0.
- Only req3 valid for 3 consecutive transactions → 3 grants to req3; rr wraps to 0; no stall cycles beyond the FSM latency.
- resetn=0 during WAIT → next cycle all outputs 0; no resp_done; fresh req1 afterwards is granted first.
- With ACPRAM_AXI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, engine never done → resp_done[owner]=1 and resp_error=1 17 cycles after ISSUE; no new grant until eng_busy=0.
